mem_bus_ctrl: RTL
=================

// Module: mem_bus_ctrl
// PURPOSE
//   Memory bus controller directly downstream of the cpu core. Consumes mem_rd/mem_wr,
//   the MAR address and the MDR write data. Runs a 4-phase req/ack handshake to external
//   memory and returns read data for the MDR, plus a busy stall to the control unit.
// PARAMETERS
//   ADDR_WIDTH      32   address width (MAR side)
//   DATA_WIDTH      32   data width (MDR side)
//   TIMEOUT_CYCLES  255  cycles in REQ without ack before abort (MEM_BUS_CTRL_TIMEOUT_EN only)
//   TO_WIDTH        8    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//   clk          in   1           rising-edge clock
//   rst_n        in   1           asynchronous active-low reset
//   mem_rd       in   1           read request from control
//   mem_wr       in   1           write request from control
//   addr         in   ADDR_WIDTH  address (MAR value)
//   wdata        in   DATA_WIDTH  write data (MDR value)
//   rdata        out  DATA_WIDTH  registered read data, to MDR load path
//   rdata_valid  out  1           one-cycle pulse: rdata updated
//   busy         out  1           transaction in flight; requests ignored
//   bus_err      out  1           sticky timeout flag (tied 0 without macro)
//   ext_addr     out  ADDR_WIDTH  latched address to memory
//   ext_wdata    out  DATA_WIDTH  latched write data to memory
//   ext_we       out  1           1 = write, 0 = read; valid while ext_req
//   ext_req      out  1           request, held until ext_ack seen
//   ext_ack      in   1           memory acknowledge; read data valid with it
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; all outputs 0, incl. ext_req, rdata, bus_err.
//     Reset mid-transaction drops ext_req at once. No completion pulse is issued.
//   States: IDLE -> REQ -> RELEASE -> IDLE.
//   IDLE: busy=0. At an edge with mem_rd|mem_wr=1, latch addr->ext_addr and wdata->ext_wdata.
//     Set ext_we=mem_wr&~mem_rd; both high is a read (write dropped). Go to REQ.
//   REQ: ext_req=1, busy=1. At an edge with ext_ack=1:
//     read: rdata<=ext_rdata, rdata_valid=1 for the next cycle only.
//     write: rdata unchanged, no rdata_valid.
//     Then go to RELEASE.
//   RELEASE: ext_req=0, busy=1. Wait for ext_ack=0, then go to IDLE. An already-low ack
//     costs one cycle.
//   busy = (state != IDLE), registered. Requests while busy are ignored; no queueing.
//   Min latency, request edge N: ext_req high N+1. Ack sampled N+2 earliest.
//     rdata_valid high in cycle N+2..N+3. Back in IDLE at N+4 if ack drops at once.
//   ext_addr/ext_wdata/ext_we are stable from REQ entry until the next accepted request.
//   bus_err clears on the next accepted request.
// CONFIGURATION
//   MEM_BUS_CTRL_TIMEOUT_EN defined:
//     TO_WIDTH counter clears on REQ entry and increments each REQ cycle without ack.
//     At count==TIMEOUT_CYCLES with ack still low: drop ext_req and set bus_err=1.
//     A read also gets rdata<=0 and an rdata_valid pulse, so control never hangs.
//     Then go to RELEASE. Ack on the same edge as the timeout wins: normal completion.
//   Undefined: no counter; REQ waits forever; bus_err tied 0.
// TESTING
//   1. Read addr=0x100, ack 3 cycles after req, ext_rdata=0xCAFEF00D -> ext_we=0,
//      ext_addr=0x100, rdata=0xCAFEF00D, rdata_valid exactly 1 cycle.
//   2. Write addr=0x20, wdata=0x12345678, ack after 1 cycle -> ext_we=1,
//      ext_wdata=0x12345678, no rdata_valid, busy drops once ack low.
//   3. mem_rd=mem_wr=1 -> read performed (ext_we=0). Second request while busy -> ignored.
//   4. Ack held high 4 cycles past completion -> ext_req stays 0, busy=1 until ack falls,
//      no second transaction.
//   5. rst_n low while in REQ -> ext_req, busy, rdata_valid 0 without waiting for an edge;
//      next request after reset handled normally.
//   6. (TIMEOUT_EN) TIMEOUT_CYCLES=4, read, never ack -> ext_req falls after 4 REQ cycles,
//      bus_err=1, rdata=0 with valid pulse. Next request clears bus_err.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
//   Memory bus controller sitting directly downstream of the cpu core. It takes
//   a read or write request from the control unit, latches the MAR address and
//   the MDR write data, and runs a 4-phase req/ack handshake to external memory:
//       IDLE -> REQ (ext_req high until ack) -> RELEASE (wait ack low) -> IDLE
//   Read data is captured on the acknowledging edge and returned on rdata with a
//   one-cycle rdata_valid pulse. busy stalls the control unit for the whole
//   transaction; requests seen while busy are dropped, never queued.
//
//   Optional feature macro: MEM_BUS_CTRL_TIMEOUT_EN
//     When defined, a REQ phase that sees no ack for TIMEOUT_CYCLES cycles is
//     aborted: ext_req drops, sticky bus_err is set, and a read completes with
//     rdata=0 plus an rdata_valid pulse so the control unit cannot hang.
//     When undefined, REQ waits indefinitely and bus_err stays 0.
//
// Ports
//   clk          in   1           rising-edge clock
//   rst_n        in   1           asynchronous active-low reset
//   mem_rd       in   1           read request from control
//   mem_wr       in   1           write request from control (mem_rd wins if both)
//   addr         in   ADDR_WIDTH  address (MAR value)
//   wdata        in   DATA_WIDTH  write data (MDR value)
//   rdata        out  DATA_WIDTH  registered read data, to MDR load path
//   rdata_valid  out  1           one-cycle pulse: rdata updated
//   busy         out  1           transaction in flight; requests ignored
//   bus_err      out  1           sticky timeout flag, cleared by next request
//   ext_addr     out  ADDR_WIDTH  latched address to memory
//   ext_wdata    out  DATA_WIDTH  latched write data to memory
//   ext_we       out  1           1 = write, 0 = read; valid while ext_req
//   ext_req      out  1           request, held until ext_ack seen
//   ext_ack      in   1           memory acknowledge; read data valid with it
//   ext_rdata    in   DATA_WIDTH  memory read data, sampled with ext_ack
// -----------------------------------------------------------------------------
module mem_bus_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  busy,
    output logic                  bus_err,
    output logic [ADDR_WIDTH-1:0] ext_addr,
    output logic [DATA_WIDTH-1:0] ext_wdata,
    output logic                  ext_we,
    output logic                  ext_req,
    input  logic                  ext_ack,
    input  logic [DATA_WIDTH-1:0] ext_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    accept_s;
    logic                    done_s;
    logic                    abort_s;
    logic                    timeout_hit_s;

    logic [DATA_WIDTH-1:0]   rdata_r;
    logic                    rdata_valid_r;
    logic                    busy_r;
    logic                    bus_err_r;
    logic [ADDR_WIDTH-1:0]   ext_addr_r;
    logic [DATA_WIDTH-1:0]   ext_wdata_r;
    logic                    ext_we_r;
    logic                    ext_req_r;

`ifdef MEM_BUS_CTRL_TIMEOUT_EN
    // The abort fires on the edge that ends the TIMEOUT_CYCLES-th REQ cycle
    // without ack, so ext_req is high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TO_WIDTH-1:0] to_cnt_r;

    assign timeout_hit_s = (to_cnt_r == TO_LAST);

    // Timeout counter: cleared on REQ entry, counts REQ cycles without ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= {TO_WIDTH{1'b0}};
        end else if (accept_s) begin
            to_cnt_r <= {TO_WIDTH{1'b0}};
        end else if ((state_r == ST_REQ) && !ext_ack) begin
            to_cnt_r <= to_cnt_r + TO_WIDTH'(1);
        end
    end
`else
    logic [TO_WIDTH-1:0] unused_to_limit_s;

    assign timeout_hit_s     = 1'b0;
    assign unused_to_limit_s = TO_WIDTH'(TIMEOUT_CYCLES);
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and per-edge event decode.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        done_s      = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_rd || mem_wr) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // An ack on the timeout edge still counts as normal completion.
                if (ext_ack) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_RELEASE;
                end else if (timeout_hit_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_RELEASE: begin
                if (!ext_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registered outputs and request latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r       <= {DATA_WIDTH{1'b0}};
            rdata_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            bus_err_r     <= 1'b0;
            ext_addr_r    <= {ADDR_WIDTH{1'b0}};
            ext_wdata_r   <= {DATA_WIDTH{1'b0}};
            ext_we_r      <= 1'b0;
            ext_req_r     <= 1'b0;
        end else begin
            // Derived from next state so they line up with the state register.
            busy_r        <= (state_nxt_s != ST_IDLE);
            ext_req_r     <= (state_nxt_s == ST_REQ);
            rdata_valid_r <= 1'b0;

            if (accept_s) begin
                ext_addr_r  <= addr;
                ext_wdata_r <= wdata;
                ext_we_r    <= mem_wr & ~mem_rd;
                bus_err_r   <= 1'b0;
            end

            if (done_s && !ext_we_r) begin
                rdata_r       <= ext_rdata;
                rdata_valid_r <= 1'b1;
            end

            // abort_s is constant 0 without the timeout feature, so bus_err
            // stays tied low in that build.
            if (abort_s) begin
                bus_err_r <= 1'b1;
                if (!ext_we_r) begin
                    rdata_r       <= {DATA_WIDTH{1'b0}};
                    rdata_valid_r <= 1'b1;
                end
            end
        end
    end

    assign rdata       = rdata_r;
    assign rdata_valid = rdata_valid_r;
    assign busy        = busy_r;
    assign bus_err     = bus_err_r;
    assign ext_addr    = ext_addr_r;
    assign ext_wdata   = ext_wdata_r;
    assign ext_we      = ext_we_r;
    assign ext_req     = ext_req_r;

endmodule
